// File: rtl/posit_int_cvt_seq.sv
// posit_int_cvt_seq: multi-cycle converter between posit<N,ES> and IW-bit
// signed/unsigned integers (FCVT.S.W / .S.WU / .W.S / .WU.S in the posit
// FPU cast slot). Sequence: IDLE -> DECODE -> ROUND -> HOLD -> IDLE, so a
// result is valid three cycles after accept. Rounding is RNE by default.
//
// Optional feature: define POSIT_CVT_RMODE_EN to honour rnd_mode_i
// (RNE/RTZ/RDN/RUP/RMM; reserved codes and DYN fall back to RNE).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   operand_i [OPW]         integer in [IW-1:0] or posit in [N-1:0]
//   op_i [2]                00 int->posit s, 01 int->posit u,
//                           10 posit->int s, 11 posit->int u
//   rnd_mode_i [3]          RISC-V rounding mode
//   tag_i / tag_o           opaque tag carried with the operation
//   in_valid_i/in_ready_o   request handshake
//   flush_i                 abort in-flight operation
//   result_o [OPW]          zero-extended result
//   status_o [5]            {NV,DZ,OF,UF,NX}
//   out_valid_o/out_ready_i result handshake
//   busy_o                  operation in flight
module posit_int_cvt_seq #(
  parameter int N     = 32,
  parameter int ES    = 2,
  parameter int IW    = 32,
  parameter int TAG_W = 4,
  localparam int OPW  = (N > IW) ? N : IW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OPW-1:0]   operand_i,
  input  logic [1:0]       op_i,
  input  logic [2:0]       rnd_mode_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [OPW-1:0]   result_o,
  output logic [4:0]       status_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  localparam int LW = 2*IW + N + 4;  // posit body string, wide enough to lose no int bits
  localparam int PW = IW + N + 2;    // fixed point: IW+2 integer bits, N fraction bits
  localparam int SW = 12;            // signed scale width
  localparam logic signed [SW-1:0] SC_MAX  = SW'(IW);
  localparam logic signed [SW-1:0] SC_NEG1 = '1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ROUND, S_HOLD} state_t;
  state_t state_q, state_d;

  logic [OPW-1:0]   opnd_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] itag_q;
`ifdef POSIT_CVT_RMODE_EN
  logic [2:0]       rnd_q;
`else
  logic             unused_rnd;
  assign unused_rnd = ^rnd_mode_i;
`endif

  logic accept;
  assign accept      = (state_q == S_IDLE) && in_valid_i && !flush_i;
  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_HOLD);
  assign busy_o      = (state_q != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:   if (in_valid_i) state_d = S_DECODE;
        S_DECODE: state_d = S_ROUND;
        S_ROUND:  state_d = S_HOLD;
        S_HOLD:   if (out_ready_i) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Decode: integer magnitude / leading one, or posit regime/exponent/fraction.
  logic [IW-1:0]          ival, imag;
  logic [N-1:0]           pval, pabs;
  logic [N-2:0]           rbits, rsh, fbits;
  logic [3:0]             pexp;
  int unsigned            lead, run;
  logic                   rstop;
  int                     kreg;
  logic                   dec_zero, dec_nar, dec_neg;
  logic signed [SW-1:0]   dec_scale;
  logic [IW-1:0]          dec_frac;
  logic [N-1:0]           dec_sig;

  always_comb begin
    dec_zero  = 1'b0;
    dec_nar   = 1'b0;
    dec_neg   = 1'b0;
    dec_scale = '0;
    dec_frac  = '0;
    dec_sig   = '0;
    ival = opnd_q[IW-1:0];
    pval = opnd_q[N-1:0];
    imag = (!op_q[0] && ival[IW-1]) ? -ival : ival;
    lead = 0;
    for (int unsigned i = 0; i < IW; i++)
      if (imag[i]) lead = i;
    pabs  = pval[N-1] ? -pval : pval;
    rbits = pabs[N-2:0];
    run   = 0;
    rstop = 1'b0;
    for (int unsigned i = 0; i < N-1; i++) begin
      if (!rstop && (rbits[N-2-i] == rbits[N-2])) run++;
      else rstop = 1'b1;
    end
    // Drop regime and terminator; exponent bits past the end read as zero.
    rsh  = rbits << (run + 1);
    pexp = '0;
    for (int unsigned j = 0; j < ES; j++)
      pexp = {pexp[2:0], rsh[N-2-j]};
    fbits = rsh << ES;
    kreg  = rbits[N-2] ? int'(run) - 1 : -int'(run);
    if (op_q[1]) begin
      dec_neg   = pval[N-1];
      dec_zero  = (pval == '0);
      dec_nar   = (pval == {1'b1, {(N-1){1'b0}}});
      dec_scale = SW'(kreg * (1 << ES) + int'(pexp));
      dec_sig   = {1'b1, fbits};
    end else begin
      dec_neg   = !op_q[0] && ival[IW-1];
      dec_zero  = (ival == '0);
      dec_scale = SW'(lead);
      dec_frac  = imag << (IW - lead);  // bits below the leading one, left-aligned
    end
  end

  logic                 dzero_q, dnar_q, dneg_q;
  logic signed [SW-1:0] dscale_q;
  logic [IW-1:0]        dfrac_q;
  logic [N-1:0]         dsig_q;

  // Round and pack.
  int                   i_k;
  logic [3:0]           i_e;
  logic [LW-1:0]        tail, body;
  logic [N-2:0]         i_p, i_pr;
  logic                 i_g, i_s, i_inc;
  logic [N-1:0]         i_res;
  logic                 p_ovf, p_tiny, p_g, p_s;
  logic [PW-1:0]        pfix;
  logic [IW+1:0]        p_int, p_rm, u_max, s_pos, s_neg;
  logic                 r_lsb, r_g, r_s, r_up;
  logic [OPW-1:0]       res;
  logic [4:0]           st;

  always_comb begin
    // int -> posit: regime of k+1 ones, terminator, exponent, fraction; the
    // whole string is rounded on the bit pattern below the kept N-1 bits.
    i_k  = int'(dscale_q) >>> ES;
    i_e  = 4'(int'(dscale_q) & ((1 << ES) - 1));
    tail = (LW'(i_e) << (LW-1-ES)) | (LW'(dfrac_q) << (LW-1-ES-IW));
    body = ~({LW{1'b1}} >> (i_k + 1)) | (tail >> (i_k + 1));
    i_p  = body[LW-1 -: N-1];
    i_g  = body[LW-N];
    i_s  = |body[LW-N-1:0];

    // posit -> int: value * 2^N as fixed point = sig << (scale+1).
    p_ovf  = dscale_q > SC_MAX;
    p_tiny = dscale_q < SC_NEG1;
    pfix   = '0;
    if (!p_ovf && !p_tiny) pfix = PW'(dsig_q) << (int'(dscale_q) + 1);
    p_int = pfix[PW-1:N];
    p_g   = pfix[N-1];
    p_s   = p_tiny | (|pfix[N-2:0]);

    r_lsb = op_q[1] ? p_int[0] : i_p[0];
    r_g   = op_q[1] ? p_g : i_g;
    r_s   = op_q[1] ? p_s : i_s;
`ifdef POSIT_CVT_RMODE_EN
    case (rnd_q)
      3'b001:  r_up = 1'b0;
      3'b010:  r_up = dneg_q & (r_g | r_s);
      3'b011:  r_up = !dneg_q & (r_g | r_s);
      3'b100:  r_up = r_g;
      default: r_up = r_g & (r_s | r_lsb);
    endcase
`else
    r_up = r_g & (r_s | r_lsb);
`endif

    i_inc = r_up && !(&i_p);  // saturate at maxpos instead of wrapping to NaR
    i_pr  = i_p + (N-1)'(i_inc);
    i_res = dneg_q ? -{1'b0, i_pr} : {1'b0, i_pr};

    p_rm  = p_int + (IW+2)'(r_up);
    u_max = {2'b00, {IW{1'b1}}};
    s_pos = {3'b000, {(IW-1){1'b1}}};
    s_neg = (IW+2)'(1) << (IW-1);

    res = '0;
    st  = '0;
    if (!op_q[1]) begin
      if (!dzero_q) begin
        res   = OPW'(i_res);
        st[0] = i_g | i_s;
      end
    end else if (dzero_q) begin
      res = '0;
    end else if (dnar_q) begin
      res   = op_q[0] ? OPW'({IW{1'b1}}) : OPW'({1'b1, {(IW-1){1'b0}}});
      st[4] = 1'b1;
    end else if (op_q[0]) begin
      if (dneg_q) begin
        if (p_rm == '0) st[0] = p_g | p_s;
        else            st[4] = 1'b1;
      end else if (p_ovf || (p_rm > u_max)) begin
        res   = OPW'({IW{1'b1}});
        st[4] = 1'b1;
      end else begin
        res   = OPW'(p_rm[IW-1:0]);
        st[0] = p_g | p_s;
      end
    end else begin
      if (p_ovf || (p_rm > (dneg_q ? s_neg : s_pos))) begin
        res   = dneg_q ? OPW'({1'b1, {(IW-1){1'b0}}}) : OPW'({1'b0, {(IW-1){1'b1}}});
        st[4] = 1'b1;
      end else begin
        res   = OPW'(dneg_q ? -p_rm[IW-1:0] : p_rm[IW-1:0]);
        st[0] = p_g | p_s;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opnd_q   <= '0;
      op_q     <= '0;
      itag_q   <= '0;
`ifdef POSIT_CVT_RMODE_EN
      rnd_q    <= '0;
`endif
      dzero_q  <= 1'b0;
      dnar_q   <= 1'b0;
      dneg_q   <= 1'b0;
      dscale_q <= '0;
      dfrac_q  <= '0;
      dsig_q   <= '0;
      result_o <= '0;
      status_o <= '0;
      tag_o    <= '0;
    end else begin
      if (accept) begin
        opnd_q <= operand_i;
        op_q   <= op_i;
        itag_q <= tag_i;
`ifdef POSIT_CVT_RMODE_EN
        rnd_q  <= rnd_mode_i;
`endif
      end
      if (state_q == S_DECODE) begin
        dzero_q  <= dec_zero;
        dnar_q   <= dec_nar;
        dneg_q   <= dec_neg;
        dscale_q <= dec_scale;
        dfrac_q  <= dec_frac;
        dsig_q   <= dec_sig;
      end
      if (state_q == S_ROUND && !flush_i) begin
        result_o <= res;
        status_o <= st;
        tag_o    <= itag_q;
      end
    end
  end

endmodule

// File: tb/tb_posit_int_cvt_seq.sv
// Bench for posit_int_cvt_seq at N=32, ES=2, IW=32: directed vector table,
// handshake corner sequences, and random operations against a real-valued
// reference model.
module tb_posit_int_cvt_seq;
  localparam int N  = 32;
  localparam int ES = 2;
  localparam int IW = 32;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] operand_i;
  logic [1:0]  op_i;
  logic [2:0]  rnd_mode_i;
  logic [3:0]  tag_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [31:0] result_o;
  logic [4:0]  status_o;
  logic [3:0]  tag_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        busy_o;

  posit_int_cvt_seq #(.N(N), .ES(ES), .IW(IW), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .operand_i(operand_i), .op_i(op_i),
    .rnd_mode_i(rnd_mode_i), .tag_i(tag_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .result_o(result_o),
    .status_o(status_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  // Value of an nb-bit posit pattern (not zero, not NaR).
  function automatic real pdec(longint unsigned p, int nb);
    longint unsigned mask = (nb == 64) ? '1 : ((64'd1 << nb) - 1);
    bit  sgn = p[nb-1];
    int  i, run, k, e;
    bit  r0;
    real f, w;
    if (sgn) p = (~p + 1) & mask;
    i = nb - 2; r0 = p[i]; run = 0;
    while (i >= 0 && p[i] == r0) begin run++; i--; end
    i--;
    k = r0 ? run - 1 : -run;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? int'(p[i]) : 0);
      i--;
    end
    f = 0.0; w = 0.5;
    while (i >= 0) begin
      if (p[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    return (sgn ? -1.0 : 1.0) * pow2(k * (1 << ES) + e) * (1.0 + f);
  endfunction

  // Nearest positive posit to x (x >= 1); ties decided by the pattern midpoint
  // (an (N+1)-bit posit), picking the even pattern.
  function automatic longint unsigned near_posit(real x);
    longint unsigned maxp = (64'd1 << (N-1)) - 1;
    longint unsigned lo = 1, hi = maxp, md;
    real m;
    if (x >= pdec(maxp, N)) return maxp;
    while (hi - lo > 1) begin
      md = (lo + hi) / 2;
      if (pdec(md, N) <= x) lo = md; else hi = md;
    end
    if (pdec(lo, N) == x) return lo;
    m = pdec((lo << 1) | 1, N + 1);
    if (x > m) return hi;
    if (x < m) return lo;
    return lo[0] ? hi : lo;
  endfunction

  task automatic ref_model(input logic [1:0] op, input logic [31:0] a,
                           output logic [31:0] r, output logic [4:0] st);
    longint mag, rm, lim;
    longint unsigned p;
    bit neg, inexact;
    real v, av, fl, fr;
    r = '0; st = '0;
    if (!op[1]) begin
      neg = !op[0] && a[31];
      mag = neg ? (64'sd4294967296 - longint'(a)) : longint'(a);
      if (mag != 0) begin
        p = near_posit(real'(mag));
        r = neg ? 32'(-p) : 32'(p);
        st[0] = (pdec(p, N) != real'(mag));
      end
    end else if (a == 32'h0) begin
      r = '0;
    end else if (a == 32'h8000_0000) begin
      r = op[0] ? 32'hFFFF_FFFF : 32'h8000_0000;
      st = 5'h10;
    end else begin
      v = pdec(longint'(a), N);
      neg = v < 0.0;
      av = neg ? -v : v;
      if (av >= pow2(IW + 1)) begin
        rm = 64'sd1 << (IW + 1); inexact = 1'b0;
      end else begin
        fl = $floor(av); fr = av - fl; rm = longint'(fl);
        inexact = (fr != 0.0);
        if (fr > 0.5 || (fr == 0.5 && rm[0])) rm++;
      end
      if (op[0]) begin
        if (neg) begin
          if (rm == 0) st = {4'b0, inexact};
          else         st = 5'h10;
        end else if (rm > (64'sd1 << IW) - 1) begin
          r = 32'hFFFF_FFFF; st = 5'h10;
        end else begin
          r = 32'(rm); st = {4'b0, inexact};
        end
      end else begin
        lim = neg ? (64'sd1 << (IW-1)) : (64'sd1 << (IW-1)) - 1;
        if (rm > lim) begin
          r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF; st = 5'h10;
        end else begin
          r = neg ? 32'(-rm) : 32'(rm); st = {4'b0, inexact};
        end
      end
    end
  endtask

  // One full operation with out_ready_i high; lat = edges until out_valid_o.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [3:0] tg,
                        output logic [31:0] r, output logic [4:0] st,
                        output logic [3:0] tgo, output int lat);
    op_i = op; operand_i = a; tag_i = tg;
`ifdef POSIT_CVT_RMODE_EN
    rnd_mode_i = 3'b000;
`else
    rnd_mode_i = 3'($urandom);
`endif
    in_valid_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      lat++;
    end while (!out_valid_o && lat < 20);
    if (!out_valid_o) lat = -1;
    r = result_o; st = status_o; tgo = tag_o;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] r;
    logic [4:0]  st;
  } vec_t;
  vec_t tbl[$];

  logic [31:0] r, er;
  logic [4:0]  st, est;
  logic [3:0]  tgo, tg;
  logic [1:0]  op;
  logic [31:0] a;
  int          lat;

  initial begin
    rst_i = 1'b1; operand_i = '0; op_i = '0; rnd_mode_i = '0; tag_i = '0;
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready_o, 1);
    chk("reset out_valid", out_valid_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset result", result_o, 0);
    chk("reset status", status_o, 0);
    chk("reset tag", tag_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    tbl.push_back('{2'b00, 32'h0000_0001, 32'h4000_0000, 5'h00});
    tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hC000_0000, 5'h00});
    tbl.push_back('{2'b00, 32'h0000_0003, 32'h4C00_0000, 5'h00});
    tbl.push_back('{2'b00, 32'h0000_0000, 32'h0000_0000, 5'h00});
    tbl.push_back('{2'b00, 32'h7FFF_FFFF, 32'h7FB0_0000, 5'h01});
    tbl.push_back('{2'b00, 32'h8000_0000, 32'h8050_0000, 5'h00});
    tbl.push_back('{2'b01, 32'h8000_0000, 32'h7FB0_0000, 5'h00});
    tbl.push_back('{2'b10, 32'h4800_0000, 32'h0000_0002, 5'h00});
    tbl.push_back('{2'b10, 32'h4400_0000, 32'h0000_0002, 5'h01});
    tbl.push_back('{2'b10, 32'h4200_0000, 32'h0000_0001, 5'h01});
    tbl.push_back('{2'b10, 32'h8000_0000, 32'h8000_0000, 5'h10});
    tbl.push_back('{2'b10, 32'hC000_0000, 32'hFFFF_FFFF, 5'h00});
    tbl.push_back('{2'b10, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'h10});
    tbl.push_back('{2'b10, 32'h3800_0000, 32'h0000_0000, 5'h01});
    tbl.push_back('{2'b10, 32'h3C00_0000, 32'h0000_0001, 5'h01});
    tbl.push_back('{2'b11, 32'hC000_0000, 32'h0000_0000, 5'h10});
    tbl.push_back('{2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'h10});
    tbl.push_back('{2'b11, 32'h0000_0000, 32'h0000_0000, 5'h00});

    foreach (tbl[i]) begin
      tg = 4'(i + 1);
      run_op(tbl[i].op, tbl[i].a, tg, r, st, tgo, lat);
      chk($sformatf("vec%0d result", i), r, tbl[i].r);
      chk($sformatf("vec%0d status", i), st, tbl[i].st);
      chk($sformatf("vec%0d tag", i), tgo, tg);
      chk($sformatf("vec%0d latency", i), lat, 3);
    end

    // Backpressure: result held 5 cycles, new request not accepted meanwhile.
    out_ready_i = 1'b0;
    op_i = 2'b00; operand_i = 32'd3; tag_i = 4'd5; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp out_valid", out_valid_o, 1);
    operand_i = 32'd1; tag_i = 4'd6; in_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp result", result_o, 32'h4C00_0000);
      chk("bp status", status_o, 0);
      chk("bp tag", tag_o, 5);
      chk("bp in_ready", in_ready_o, 0);
      chk("bp out_valid held", out_valid_o, 1);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", in_ready_o, 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      lat++;
    end while (!out_valid_o && lat < 20);
    chk("bp next latency", lat, 3);
    chk("bp next result", result_o, 32'h4000_0000);
    chk("bp next tag", tag_o, 6);
    @(posedge clk); #1;

    // Reset while in ROUND.
    op_i = 2'b00; operand_i = 32'd3; tag_i = 4'd9; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst mid out_valid", out_valid_o, 0);
    chk("rst mid in_ready", in_ready_o, 1);
    chk("rst mid busy", busy_o, 0);
    chk("rst mid result", result_o, 0);
    chk("rst mid status", status_o, 0);
    chk("rst mid tag", tag_o, 0);

    // Flush in DECODE.
    op_i = 2'b10; operand_i = 32'h4800_0000; tag_i = 4'd3; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush busy", busy_o, 0);
    chk("flush in_ready", in_ready_o, 1);
    chk("flush out_valid", out_valid_o, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("flush no result", out_valid_o, 0);
    end
    // Flush beats a same-cycle accept.
    in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush vs accept busy", busy_o, 0);

    // Random operations against the reference model.
    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(0, 1000))
                                                 : 32'($urandom_range(0, 1000));
        default: a = {8'($urandom_range(8'h30, 8'h58)), 24'($urandom)};
      endcase
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? -a : a;
      tg = 4'($urandom_range(0, 15));
      ref_model(op, a, er, est);
      run_op(op, a, tg, r, st, tgo, lat);
      chk($sformatf("rand op%0d a=%0h result", op, a), r, er);
      chk($sformatf("rand op%0d a=%0h status", op, a), st, est);
      chk("rand tag", tgo, tg);
      chk("rand latency", lat, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
